// File: rtl/irq_prio_ctrl.sv
// Fixed-priority interrupt controller: synchronised lines, edge/level triggers, masking,
// nested in-service tracking and a registered request with take/ret handshake.
module irq_prio_ctrl #(
    parameter int NUM_IRQ = 3,
    parameter int ID_W = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               irq_ie,
    input  logic               irq_take,
    input  logic               irq_ret,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] irw,
    output logic [NUM_IRQ-1:0] in_svc,
    output logic [NUM_IRQ-1:0] irq_lost
);

    logic [NUM_IRQ-1:0] sync1, sync2, sync3;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] edge_trig, trig, take_vec, ret_clear, elig;
    logic [NUM_IRQ-1:0] pend_next, svc_next, lost_next;
    logic               take_fire, cand_valid, svc_valid, req_next;
    logic [ID_W-1:0]    cand_idx, svc_idx, id_next;

    always_comb begin
        edge_trig = sync2 & ~sync3;
        trig      = (edge_trig & EDGE_MASK) | (sync2 & ~EDGE_MASK);
        take_fire = irq_take & irq_req;

        take_vec  = '0;
        ret_clear = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (take_fire && irq_id == ID_W'(i)) take_vec[i] = 1'b1;
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (in_svc[i]) begin
                ret_clear    = '0;
                ret_clear[i] = irq_ret;
            end
        end

        svc_next  = (in_svc & ~ret_clear) | take_vec;
        // A trigger arriving in the same cycle as the take keeps the channel pending.
        pend_next = (pending & ~take_vec) | trig;
        lost_next = (irq_lost & ~take_vec) | (edge_trig & EDGE_MASK & pending & ~take_vec);

        // Arbitrate against post-take state so irq_req drops right after an accepted take.
        elig       = pending & ~take_vec & irq_mask;
        cand_valid = 1'b0;
        cand_idx   = '0;
        svc_valid  = 1'b0;
        svc_idx    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (elig[i]) begin
                cand_valid = 1'b1;
                cand_idx   = ID_W'(i);
            end
            if (svc_next[i]) begin
                svc_valid = 1'b1;
                svc_idx   = ID_W'(i);
            end
        end

        req_next = irq_ie && cand_valid && (!svc_valid || cand_idx > svc_idx);
        id_next  = req_next ? cand_idx : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            pending  <= '0;
            in_svc   <= '0;
            irq_lost <= '0;
            irq_req  <= 1'b0;
            irq_id   <= '0;
        end else begin
            sync1    <= irq;
            sync2    <= sync1;
            sync3    <= sync2;
            pending  <= pend_next;
            in_svc   <= svc_next;
            irq_lost <= lost_next;
            irq_req  <= req_next;
            irq_id   <= id_next;
        end
    end

    assign irw = pending;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: directed scenarios plus random traffic, all outputs compared
// every cycle against a stack-based behavioural model of the controller.
module tb_irq_prio_ctrl;
    localparam logic [2:0] EM = 3'b011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] irq = '0;
    logic [2:0] irq_mask = 3'b111;
    logic       irq_ie = 1'b1;
    logic       irq_take = 1'b0;
    logic       irq_ret = 1'b0;
    logic       irq_req;
    logic [1:0] irq_id;
    logic [2:0] irw, in_svc, irq_lost;

    int n_tests = 0;
    int n_fail = 0;

    irq_prio_ctrl #(.NUM_IRQ(3), .ID_W(2), .EDGE_MASK(EM)) dut (
        .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask), .irq_ie(irq_ie),
        .irq_take(irq_take), .irq_ret(irq_ret), .irq_req(irq_req), .irq_id(irq_id),
        .irw(irw), .in_svc(in_svc), .irq_lost(irq_lost)
    );

    always #5 clk = ~clk;

    // Reference model: sampled-line history, pending/lost flags, and a stack of nested handlers.
    bit [2:0] hist[3];
    bit       m_pend[3];
    bit       m_lost[3];
    int       stk[$];
    bit       m_req;
    int       m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] pack(input bit a[3]);
        return {a[2], a[1], a[0]};
    endfunction

    function automatic logic [2:0] svc_bits();
        logic [2:0] v = '0;
        foreach (stk[k]) v[stk[k]] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '0;
            m_pend[i] = 0;
            m_lost[i] = 0;
        end
        stk.delete();
        m_req = 0;
        m_id = 0;
    endtask

    task automatic model_update();
        int  taken;
        int  cand;
        int  top;
        bit  new_pend[3];
        bit  rise, trg;
        taken = (irq_take && m_req) ? m_id : -1;
        cand = -1;
        for (int i = 0; i < 3; i++) begin
            rise = hist[1][i] && !hist[2][i];
            trg  = EM[i] ? rise : hist[1][i];
            if (taken == i) m_lost[i] = 0;
            else if (EM[i] && rise && m_pend[i]) m_lost[i] = 1;
            new_pend[i] = (m_pend[i] && taken != i) || trg;
            if (m_pend[i] && taken != i && irq_mask[i]) cand = i;
        end
        if (irq_ret && stk.size() > 0) void'(stk.pop_back());
        if (taken >= 0) stk.push_back(taken);
        top = (stk.size() > 0) ? stk[$] : -1;
        m_req = irq_ie && cand >= 0 && cand > top;
        m_id = m_req ? cand : 0;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = irq;
        m_pend = new_pend;
    endtask

    task automatic compare_all();
        check("irq_req", irq_req, m_req);
        check("irq_id", irq_id, m_id);
        check("irw", irw, pack(m_pend));
        check("in_svc", in_svc, svc_bits());
        check("irq_lost", irq_lost, pack(m_lost));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        irq = '0;
        irq_mask = 3'b111;
        irq_ie = 1'b1;
        irq_take = 1'b0;
        irq_ret = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b1;
    endtask

    task automatic pulse_irq(input logic [2:0] v);
        irq = v;
        step();
        irq = '0;
    endtask

    task automatic take_pulse();
        irq_take = 1'b1;
        step();
        irq_take = 1'b0;
    endtask

    task automatic ret_pulse();
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
    endtask

    task automatic wait_req(input int max);
        int n = 0;
        while (!irq_req && n < max) begin
            step();
            n++;
        end
        check("wait_req", irq_req, 1);
    endtask

    initial begin
        model_reset();
        // Scenario 1: latency and single take
        do_reset();
        check("reset_req", irq_req, 0);
        pulse_irq(3'b001);
        step();
        step();
        check("lat_e2_req", irq_req, 0);
        step();
        check("lat_e3_req", irq_req, 1);
        check("lat_e3_id", irq_id, 0);
        take_pulse();
        check("t1_irw", irw, 3'b000);
        check("t1_svc", in_svc, 3'b001);
        check("t1_req", irq_req, 0);
        ret_pulse();

        // Scenario 2: priority between simultaneous lines
        do_reset();
        pulse_irq(3'b101);
        wait_req(8);
        check("t2_id_hi", irq_id, 2);
        take_pulse();
        ret_pulse();
        wait_req(4);
        check("t2_id_lo", irq_id, 0);
        take_pulse();
        ret_pulse();
        check("t2_irw", irw, 3'b000);
        check("t2_svc", in_svc, 3'b000);

        // Scenario 3: nesting
        do_reset();
        pulse_irq(3'b001);
        wait_req(8);
        take_pulse();
        pulse_irq(3'b010);
        wait_req(8);
        check("t3_id1", irq_id, 1);
        take_pulse();
        check("t3_svc011", in_svc, 3'b011);
        pulse_irq(3'b001);
        steps(5);
        check("t3_blocked", irq_req, 0);
        check("t3_irw", irw, 3'b001);
        ret_pulse();
        check("t3_svc001", in_svc, 3'b001);
        check("t3_still_blk", irq_req, 0);
        ret_pulse();
        check("t3_svc000", in_svc, 3'b000);
        check("t3_req0", irq_req, 1);
        check("t3_id0", irq_id, 0);
        take_pulse();
        ret_pulse();

        // Scenario 4: masking
        do_reset();
        irq_mask = 3'b011;
        pulse_irq(3'b100);
        steps(5);
        check("t4_irw", irw, 3'b100);
        check("t4_masked", irq_req, 0);
        irq_mask = 3'b111;
        step();
        check("t4_unmask_req", irq_req, 1);
        check("t4_unmask_id", irq_id, 2);
        take_pulse();
        ret_pulse();

        // Scenario 5: lost edges and a held level line
        do_reset();
        pulse_irq(3'b010);
        steps(2);
        pulse_irq(3'b010);
        steps(3);
        check("t5_lost", irq_lost, 3'b010);
        wait_req(4);
        take_pulse();
        check("t5_lost_clr", irq_lost, 3'b000);
        ret_pulse();
        irq = 3'b100;
        wait_req(8);
        check("t5_lvl_id", irq_id, 2);
        take_pulse();
        irq = 3'b100;
        check("t5_lvl_repend", irw, 3'b100);
        check("t5_lvl_svc", in_svc, 3'b100);
        irq = 3'b000;
        steps(4);
        ret_pulse();
        wait_req(4);
        take_pulse();
        ret_pulse();
        steps(3);

        // Scenario 6: asynchronous reset mid-handler
        do_reset();
        pulse_irq(3'b010);
        wait_req(8);
        take_pulse();
        pulse_irq(3'b100);
        wait_req(8);
        check("t6_pre_svc", in_svc, 3'b010);
        @(posedge clk);
        model_update();
        #2 rst = 1'b0;
        #1;
        check("t6_req", irq_req, 0);
        check("t6_id", irq_id, 0);
        check("t6_irw", irw, 0);
        check("t6_svc", in_svc, 0);
        check("t6_lost", irq_lost, 0);
        do_reset();
        steps(5);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            irq = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) irq_mask = 3'($urandom_range(0, 7));
            irq_ie = ($urandom_range(0, 9) != 0);
            irq_take = (irq_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
            irq_ret = ($urandom_range(0, 5) == 0);
            step();
        end
        irq = '0;
        irq_take = 1'b0;
        irq_ret = 1'b0;
        steps(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
